// File: rtl/pio_arb_pkg.sv
// Shared types, constants and the rotate-priority search for the PIO memory arbiter.
package pio_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam int DATA_W_DEF = 512;
    localparam int CNT_W      = 16;
    localparam int MAX_REQ    = 8;

    // First set bit of req searching upward from last+1, wrapping within n requesters.
    function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] req,
                                                     input logic [2:0] last,
                                                     input int n);
        logic [MAX_REQ-1:0] g;
        int idx;
        g = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(last) + i) % n;
            if (i <= n && g == '0 && req[idx[2:0]])
                g[idx[2:0]] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/pio_rr_picker.sv
// Combinational rotate-priority picker: one-hot grant, its index, and whether anything requested.
module pio_rr_picker
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    logic [MAX_REQ-1:0] req8;
    logic [MAX_REQ-1:0] g8;

    always_comb begin
        req8                = '0;
        req8[NUM_REQ-1:0]   = req;
        g8                  = rr_onehot(req8, 3'(last_grant), NUM_REQ);
        grant               = g8[NUM_REQ-1:0];
        any                 = |g8;
        index               = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (g8[i]) index = IDX_W'(i);
    end

endmodule

// File: rtl/pio_mem_arb.sv
// Round-robin token arbiter with burst hold sharing one registered PIO output among NUM_REQ FIFOs.
// Optional per-FIFO grant counters are built when PIO_ARB_STATS_EN is defined.
module pio_mem_arb
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 2
) (
    input  logic                        user_clk,
    input  logic                        user_reset,
    input  logic [NUM_REQ-1:0]          i_req,
    output logic [NUM_REQ-1:0]          o_tkn,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_ack_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    output logic                        o_req_valid,
    output logic                        o_ack_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic [$clog2(NUM_REQ)-1:0]  o_src_id,
    input  logic                        i_tready
`ifdef PIO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]    o_grant_cnt,
    input  logic                        i_stats_clr
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [2:0] BURST_LIM = 3'(MAX_BURST - 1);

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [2:0]         burst_cnt;

    logic               out_vld, can_issue, hold_burst;
    logic [NUM_REQ-1:0] pick_grant, tkn;
    logic [IDX_W-1:0]   pick_idx, tkn_idx;
    logic               pick_any, tkn_any;

    pio_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req        (i_req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .index      (pick_idx),
        .any        (pick_any)
    );

    assign out_vld    = o_req_valid | o_ack_valid;
    assign can_issue  = ~out_vld | i_tready;
    assign hold_burst = can_issue && (state == BURST) && i_req[last_grant] && (burst_cnt < BURST_LIM);

    // Burst re-grant has priority; otherwise rotate in the same cycle so there is no bubble.
    always_comb begin
        tkn     = '0;
        tkn_idx = pick_idx;
        if (!user_reset && can_issue) begin
            if (hold_burst) begin
                tkn     = NUM_REQ'(1) << last_grant;
                tkn_idx = last_grant;
            end else if (pick_any) begin
                tkn = pick_grant;
            end
        end
    end

    assign tkn_any = |tkn;
    assign o_tkn   = tkn;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            o_req_valid <= 1'b0;
            o_ack_valid <= 1'b0;
            o_data      <= '0;
            o_src_id    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            state       <= IDLE;
        end else if (can_issue) begin
            o_req_valid <= tkn_any & i_req_valid[tkn_idx];
            o_ack_valid <= tkn_any & i_ack_valid[tkn_idx];
            if (tkn_any) begin
                o_data     <= i_data[tkn_idx*DATA_W +: DATA_W];
                o_src_id   <= tkn_idx;
                last_grant <= tkn_idx;
            end
            burst_cnt <= hold_burst ? burst_cnt + 3'd1 : 3'd0;
            state     <= (tkn_any && MAX_BURST > 1) ? BURST : IDLE;
        end
    end

`ifdef PIO_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        always_ff @(posedge user_clk) begin
            if (user_reset || i_stats_clr)
                grant_cnt[k] <= '0;
            else if (tkn[k] && grant_cnt[k] != '1)
                grant_cnt[k] <= grant_cnt[k] + 1'b1;
        end
        assign o_grant_cnt[k*CNT_W +: CNT_W] = grant_cnt[k];
    end
`endif

endmodule
